// File: rtl/instr_fields_pkg.sv
// Field widths, bit positions and the split-instruction record shared by the
// instruction splitter and its field extractor.
package instr_fields_pkg;

  localparam int OP_W      = 6;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 16;
  localparam int SHAMT_W   = 5;
  localparam int FUNCT_W   = 6;
  localparam int JH_W      = 4;
  localparam int JL_W      = 28;
  localparam int TGT_W     = 26;

  localparam int OP_LSB    = 32 - OP_W;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [31:0]        imm;
    logic [JH_W-1:0]    jmp_high;
    logic [JL_W-1:0]    jmp_low;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_extract.sv
// Combinational split of an instruction word and its PC into decoder fields.
// SPLIT_IMM_SIGN_EXT_EN selects sign- instead of zero-extension of imm.
module instr_field_extract
  import instr_fields_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  output instr_fields_t fields
);

  logic [31:0] pc_next;

  assign pc_next = pc + 32'd4;

  always_comb begin
    fields          = '0;
    fields.opcode   = instr[OP_LSB +: OP_W];
    fields.rs       = instr[RS_LSB +: REG_W];
    fields.rt       = instr[RT_LSB +: REG_W];
    fields.rd       = instr[RD_LSB +: REG_W];
    fields.shamt    = instr[SHAMT_LSB +: SHAMT_W];
    fields.funct    = instr[FUNCT_LSB +: FUNCT_W];
`ifdef SPLIT_IMM_SIGN_EXT_EN
    fields.imm      = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
`else
    fields.imm      = {{(32-IMM_W){1'b0}}, instr[IMM_W-1:0]};
`endif
    fields.jmp_high = pc_next[31:32-JH_W];
    fields.jmp_low  = {instr[TGT_W-1:0], 2'b00};
  end

endmodule

// File: rtl/instr_word_splitter.sv
// Fetch-to-decode stage: splits each accepted word into fields and holds it in a
// MAIN/SKID pair so decode back-pressure never drops a word. Imm extension via SPLIT_IMM_SIGN_EXT_EN.
module instr_word_splitter #(
  parameter int OP_W  = 6,
  parameter int REG_W = 5,
  parameter int IMM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  opcode,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [31:0]      imm,
  output logic [3:0]       jmp_high,
  output logic [27:0]      jmp_low,
  output logic [CNT_W-1:0] acc_count
);
  import instr_fields_pkg::*;

  instr_fields_t in_fields;
  instr_fields_t main_q;
  instr_fields_t skid_q;
  logic          main_vld;
  logic          skid_vld;
  logic          accept;
  logic          main_free;

  instr_field_extract u_extract (
    .instr  (in_instr),
    .pc     (in_pc),
    .fields (in_fields)
  );

  // in_ready is purely a function of registered SKID occupancy
  assign in_ready  = ~skid_vld;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_vld | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= in_fields;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= in_fields;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc_count <= '0;
    else if (accept) acc_count <= acc_count + 1'b1;
  end

  assign out_valid = main_vld;
  assign opcode    = main_q.opcode;
  assign rs        = main_q.rs;
  assign rt        = main_q.rt;
  assign rd        = main_q.rd;
  assign shamt     = main_q.shamt;
  assign funct     = main_q.funct;
  assign imm       = main_q.imm;
  assign jmp_high  = main_q.jmp_high;
  assign jmp_low   = main_q.jmp_low;

endmodule
